line_mem_responder: RTL and testbench

Responder end of the 256-bit cacheline memory interface: accepts single-line read and write requests from the arbiter's `mem_*` port, services them from an internal line-addressed RAM after a fixed, programmable latency, and returns a one-cycle `mem_resp` pulse. It stands in for physical memory behind the arbiter, both in simulation and in FPGA builds, and defines the timing that every cache and arbiter upstream must tolerate.

---
 rtl/line_mem_responder.sv | 131 +++++++++++++
 tb/tb_line_mem_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
// Responder for the 256-bit cacheline memory port. Each accepted request is
// serviced from a line-addressed RAM and answered with a one-cycle mem_resp.
module line_mem_responder #(
   parameter int LINE_IDX_W = 8,
   parameter int LATENCY    = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [31:0]  mem_addr,
   input  logic [255:0] mem_wdata,
   output logic         mem_resp,
   output logic [255:0] mem_rdata
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int DEPTH = 1 << LINE_IDX_W;

   // The accept cycle counts as cycle 0, so mem_resp lands in cycle LATENCY.
   // BUSY therefore spans LATENCY-1 cycles; LATENCY=1 goes straight to RESP.
   localparam bit         DIRECT_RESP = (LATENCY <= 1);
   localparam logic [7:0] CNT_LOAD    = 8'((LATENCY > 1) ? (LATENCY - 2) : 0);

   logic [1:0]            state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  op_write_q, op_write_d;
   logic [LINE_IDX_W-1:0] idx_q, idx_d;
   logic [255:0]          wdata_q, wdata_d;
   logic                  resp_q, resp_d;
   logic [255:0]          rdata_q;
   logic [255:0]          ram_q [DEPTH];

   logic                  req;
   logic                  commit;
   logic                  cur_write;
   logic [LINE_IDX_W-1:0] cur_idx;
   logic [255:0]          cur_wdata;
   logic                  ram_we;
   logic                  unused_addr_bits;

   assign req              = mem_read | mem_write;
   assign unused_addr_bits = ^{mem_addr[31:5+LINE_IDX_W], mem_addr[4:0]};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_write_d = op_write_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      commit     = 1'b0;
      cur_write  = op_write_q;
      cur_idx    = idx_q;
      cur_wdata  = wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               // Write wins when both strobes are high.
               op_write_d = mem_write;
               idx_d      = mem_addr[5+LINE_IDX_W-1:5];
               wdata_d    = mem_wdata;
               cur_write  = mem_write;
               cur_idx    = mem_addr[5+LINE_IDX_W-1:5];
               cur_wdata  = mem_wdata;
               if (DIRECT_RESP) begin
                  state_d = ST_RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = ST_BUSY;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         ST_BUSY: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      resp_d = (state_d == ST_RESP);
   end

   // Gating with rst_n keeps a write from landing while reset is held.
   assign ram_we = rst_n & commit & cur_write;

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_q[cur_idx] <= cur_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 8'd0;
         op_write_q <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         resp_q     <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_write_q <= op_write_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         resp_q     <= resp_d;
         if (commit && !cur_write) begin
            rdata_q <= ram_q[cur_idx];
         end
      end
   end

   assign mem_resp  = resp_q;
   assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: a LATENCY=4 instance for the main
// scenarios and a LATENCY=1 instance for back-to-back reads.
module tb_line_mem_responder;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         rd4, wr4, rd1, wr1;
   logic [31:0]  addr4, addr1;
   logic [255:0] wd4, wd1;
   logic         resp4, resp1;
   logic [255:0] rdata4, rdata1;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct packed {
      logic [255:0] rdata;
      int           cyc;
   } exp_t;

   exp_t         q4[$];
   exp_t         q1[$];
   logic [255:0] exp_rd4;

   localparam logic [255:0] D_DEAD = {8{32'hDEADBEEF}};
   localparam logic [255:0] D_1234 = {8{32'h12345678}};
   localparam logic [255:0] D_ALIA = {8{32'hCAFEF00D}};
   localparam logic [255:0] D_OLD  = {8{32'h0BADC0DE}};
   localparam logic [255:0] D_NEW  = {8{32'h600DF00D}};
   localparam logic [255:0] D_A5   = {8{32'hA5A5A5A5}};
   localparam logic [255:0] D_FF   = {8{32'hFFFF0000}};
   localparam logic [255:0] D_L1   = {8{32'h13579BDF}};

   line_mem_responder #(.LINE_IDX_W(8), .LATENCY(4)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(rd4), .mem_write(wr4),
      .mem_addr(addr4), .mem_wdata(wd4), .mem_resp(resp4), .mem_rdata(rdata4)
   );

   line_mem_responder #(.LINE_IDX_W(8), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1),
      .mem_addr(addr1), .mem_wdata(wd1), .mem_resp(resp1), .mem_rdata(rdata1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (resp4 === 1'b1) begin
         exp_t e;
         chk("resp4_expected", 256'(q4.size() > 0), 256'(1));
         if (q4.size() > 0) begin
            e = q4.pop_front();
            chk("resp4_cycle", 256'(cyc), 256'(e.cyc));
            chk("rdata4", rdata4, e.rdata);
         end
      end
   end

   always @(negedge clk) begin
      if (resp1 === 1'b1) begin
         exp_t e;
         chk("resp1_expected", 256'(q1.size() > 0), 256'(1));
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("resp1_cycle", 256'(cyc), 256'(e.cyc));
            chk("rdata1", rdata1, e.rdata);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Holds the request until mem_resp, then drops it in the following cycle.
   task automatic wait_done(input bit sel);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if ((sel ? resp1 : resp4) === 1'b1) seen = 1'b1;
      end
      chk(sel ? "resp1_timeout" : "resp4_timeout", 256'(seen), 256'(1));
      @(posedge clk); #1;
      if (sel) begin rd1 = 1'b0; wr1 = 1'b0; end
      else begin rd4 = 1'b0; wr4 = 1'b0; end
   endtask

   task automatic write4(input logic [31:0] a, input logic [255:0] d);
      rd4 = 1'b0; wr4 = 1'b1; addr4 = a; wd4 = d;
      q4.push_back('{rdata: exp_rd4, cyc: cyc + 4});
      wait_done(1'b0);
   endtask

   task automatic read4(input logic [31:0] a, input logic [255:0] d);
      rd4 = 1'b1; wr4 = 1'b0; addr4 = a; wd4 = '0;
      exp_rd4 = d;
      q4.push_back('{rdata: exp_rd4, cyc: cyc + 4});
      wait_done(1'b0);
   endtask

   task automatic pulse_reset_in_cycle2();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0; rd4 = 1'b0; wr4 = 1'b0;
      exp_rd4 = '0;
      @(posedge clk); #1;
      chk("rst_resp4", 256'(resp4), 256'(0));
      chk("rst_rdata4", rdata4, 256'(0));
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      rd4 = 1'b0; wr4 = 1'b0; addr4 = '0; wd4 = '0;
      rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
      exp_rd4 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_resp4", 256'(resp4), 256'(0));
      chk("reset_rdata4", rdata4, 256'(0));
      chk("reset_resp1", 256'(resp1), 256'(0));
      chk("reset_rdata1", rdata1, 256'(0));
      rst_n = 1'b1;

      // Preload line 3, read it once so mem_rdata is nonzero, then reset mid-read.
      write4(32'h0000_0060, D_DEAD);
      read4(32'h0000_0060, D_DEAD);
      rd4 = 1'b1; addr4 = 32'h0000_0060;
      pulse_reset_in_cycle2();
      read4(32'h0000_0060, D_DEAD);

      // Write then read the same line.
      write4(32'h0000_0100, D_1234);
      read4(32'h0000_0100, D_1234);

      // A write cut short by reset must leave the RAM untouched.
      wr4 = 1'b1; addr4 = 32'h0000_0100; wd4 = D_FF;
      pulse_reset_in_cycle2();
      read4(32'h0000_0100, D_1234);

      // Aliasing above the index and ignored offset bits.
      write4(32'h0000_2020, D_ALIA);
      read4(32'h0000_003F, D_ALIA);

      // Input churn during BUSY.
      write4(32'h0000_0180, D_OLD);
      rd4 = 1'b0; wr4 = 1'b1; addr4 = 32'h0000_0140; wd4 = D_NEW;
      q4.push_back('{rdata: exp_rd4, cyc: cyc + 4});
      @(posedge clk); #1;
      addr4 = 32'h0000_0180; wd4 = D_FF; wr4 = 1'b0;
      @(posedge clk); #1;
      addr4 = 32'h0000_01C0; wd4 = ~D_FF;
      wait_done(1'b0);
      read4(32'h0000_0140, D_NEW);
      read4(32'h0000_0180, D_OLD);

      // Read and write together: serviced as a write, mem_rdata keeps D_OLD.
      rd4 = 1'b1; wr4 = 1'b1; addr4 = 32'h0000_00E0; wd4 = D_A5;
      q4.push_back('{rdata: exp_rd4, cyc: cyc + 4});
      wait_done(1'b0);
      chk("both_rdata_hold", rdata4, D_OLD);
      read4(32'h0000_00E0, D_A5);

      // LATENCY=1: preload line 0, then hold the read for four responses.
      wr1 = 1'b1; addr1 = 32'h0; wd1 = D_L1;
      q1.push_back('{rdata: 256'(0), cyc: cyc + 1});
      wait_done(1'b1);
      rd1 = 1'b1; addr1 = 32'h0;
      for (int k = 0; k < 4; k++) begin
         q1.push_back('{rdata: D_L1, cyc: cyc + 1 + 2 * k});
      end
      repeat (8) @(posedge clk);
      #1;
      rd1 = 1'b0;
      repeat (6) @(posedge clk);
      #1;

      chk("q4_drained", 256'(q4.size()), 256'(0));
      chk("q1_drained", 256'(q1.size()), 256'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
